dispatch_scoreboard: RTL and testbench
======================================

Name: dispatch_scoreboard

Overview:
- Parametrised dispatch stage for the tensor-core scoreboard pipeline.
- Sits between fetch and issue, and generalises the fixed 5-FU dispatch to NFU functional units and NREGS registers.
- Owns a register result status (RST) table. Produces a source tag per operand and a one-hot FU status-table write enable.
- Freezes on structural, WAW and branch hazards; holds dispatch until an outstanding branch resolves, and pulses jump on a mispredict.

Parameters:
- NREGS, 32, architectural register count (power of 2); REGW = $clog2(NREGS).
- NFU, 5, number of functional units; FUW = $clog2(NFU).
- TAGW, $clog2(NFU+1), tag width; tag 0 = operand ready, tag k = pending on FU k-1.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetched instruction present
- fetch_fu  in  FUW  target FU index
- fetch_rd, fetch_rs1, fetch_rs2  in  REGW  register specifiers
- fetch_wr_en  in  1  instruction writes rd
- fetch_is_branch  in  1  instruction is a branch
- fu_busy  in  NFU  FU status-table busy bits from issue
- wb_valid  in  1  writeback this cycle
- wb_rd  in  REGW  writeback register
- wb_fu  in  FUW  FU completing the writeback
- branch_resolved  in  1  execute resolved the outstanding branch
- branch_miss  in  1  qualifies branch_resolved: mispredicted
- freeze  out  1  combinational stall to fetch
- disp_valid  out  1  registered: dispatch packet valid
- disp_fu  out  FUW  registered FU index
- disp_rd  out  REGW  registered destination register
- disp_t1, disp_t2  out  TAGW  registered source tags
- fust_en  out  NFU  registered one-hot FU status-table write enable
- jump  out  1  registered one-cycle pulse on mispredict

Behaviour:
- Reset (async, nRST=0):
  - All RST entries = 0; FSM = RUN.
  - disp_valid=0, disp_fu=0, disp_rd=0, disp_t1=0, disp_t2=0, fust_en=0, jump=0.
  - A reset mid-operation discards all pending tags and any branch wait.
- RST post-writeback view (rst'):
  - rst'[r] = 0 when wb_valid && wb_rd==r && rst[r]==wb_fu+1; otherwise rst'[r] = rst[r].
  - A writeback whose tag does not match the entry is ignored.
- Register 0: its entry always reads 0 and is never written.
- accept = fetch_valid && state==RUN && !fu_busy[fetch_fu] && !(fetch_wr_en && fetch_rd!=0 && rst'[fetch_rd]!=0) && !(branch_resolved && branch_miss).
- freeze = fetch_valid && !accept. Combinational; fetch holds its instruction while freeze is high.
- On accept, registered the next cycle (1-cycle latency):
  - disp_valid=1; fust_en = 1<<fetch_fu.
  - disp_t1 = rst'[rs1]; disp_t2 = rst'[rs2]. A same-cycle writeback bypasses, giving a tag of 0.
  - If fetch_wr_en && rd!=0, then rst[rd] <= fetch_fu+1. This write takes priority over a same-cycle writeback clear of the same rd.
- No accept: disp_valid=0, fust_en=0. The other disp_* outputs hold their last values.
- Self-dependence (rs==rd): the source tag uses the pre-dispatch value rst'.
- FSM:
  - RUN: accepting a branch moves to BR_WAIT.
  - BR_WAIT: no dispatch. On branch_resolved, go to RUN. If branch_miss is also set, jump=1 for exactly one cycle and the fetch input is squashed that cycle (no accept).
  - branch_resolved while in RUN with no branch pending is ignored (jump stays 0).
- fu_busy is sampled combinationally. Issue deasserts busy when the FU retires; dispatch does not track busy itself.
- Tags saturate cleanly: NFU+1 values fit in TAGW by construction. FU indices >= NFU are illegal (assertion in the bench).

Optional Feature:
- DISPATCH_STATS_EN defined adds three outputs:
  - stat_dispatched: 32-bit count of accepts.
  - stat_freeze: 32-bit count of cycles with freeze=1.
  - stat_br_miss: 16-bit count of jump pulses.
- All three counters saturate at all-ones and reset to 0 on nRST.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold nRST=0 while the RST table is populated -> all outputs 0; after release, an instruction with rs1=5 and rs2=6 dispatches with disp_t1=0 and disp_t2=0.
- RAW tag: dispatch FU2 writing r7, then FU0 reading rs1=r7 -> second packet has disp_t1=3, disp_t2=0, fust_en=5'b00001.
- WAW/structural hazards:
  - FU1 writes r9, then a FU3 write to r9 -> freeze=1 until wb_valid with wb_rd=9, wb_fu=1. Dispatch happens in that same cycle, and rst[9] becomes 4.
  - fu_busy[2]=1 -> freeze on any FU2 instruction.
- WB bypass and stale WB:
  - wb r4 from FU0 in the same cycle as a read of r4 -> disp_t1=0.
  - wb r4 from FU1 while rst[4]=1 -> entry unchanged.
- Branch miss: dispatch a branch -> freeze=1 on the following instructions; after branch_resolved=1 with branch_miss=1, jump=1 for one cycle with disp_valid=0; the next cycle is back in RUN and accepts.
- r0 and stats: writes to r0 never set a tag. With DISPATCH_STATS_EN defined, 10 accepts and 3 freeze cycles read back as 10 and 3.

Source files
------------

// File: rtl/dispatch_scoreboard.sv
// dispatch_scoreboard: parametrised dispatch stage between fetch and issue.
// Tracks pending results in a register result status (RST) table. Each
// dispatch packet carries a source tag per operand: tag 0 means the operand
// is ready, and tag k means it is pending on FU k-1. Dispatch freezes on
// structural hazards, WAW hazards and outstanding branches. A mispredict
// produces a single-cycle jump pulse.
// Optional build macro: DISPATCH_STATS_EN adds saturating statistics counters.
module dispatch_scoreboard #(
  parameter int NREGS = 32,
  parameter int NFU   = 5,
  parameter int REGW  = $clog2(NREGS),
  parameter int FUW   = $clog2(NFU),
  parameter int TAGW  = $clog2(NFU + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            fetch_valid,
  input  logic [FUW-1:0]  fetch_fu,
  input  logic [REGW-1:0] fetch_rd,
  input  logic [REGW-1:0] fetch_rs1,
  input  logic [REGW-1:0] fetch_rs2,
  input  logic            fetch_wr_en,
  input  logic            fetch_is_branch,
  input  logic [NFU-1:0]  fu_busy,
  input  logic            wb_valid,
  input  logic [REGW-1:0] wb_rd,
  input  logic [FUW-1:0]  wb_fu,
  input  logic            branch_resolved,
  input  logic            branch_miss,
  output logic            freeze,
  output logic            disp_valid,
  output logic [FUW-1:0]  disp_fu,
  output logic [REGW-1:0] disp_rd,
  output logic [TAGW-1:0] disp_t1,
  output logic [TAGW-1:0] disp_t2,
  output logic [NFU-1:0]  fust_en,
  output logic            jump
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]     stat_dispatched,
  output logic [31:0]     stat_freeze,
  output logic [15:0]     stat_br_miss
`endif
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_t;

  localparam logic [TAGW-1:0] TAG_ZERO = {TAGW{1'b0}};
  localparam logic [TAGW-1:0] TAG_ONE  = {{(TAGW-1){1'b0}}, 1'b1};
  localparam logic [NFU-1:0]  FU_ONE   = {{(NFU-1){1'b0}}, 1'b1};
  localparam logic [REGW-1:0] REG_ZERO = {REGW{1'b0}};
  localparam logic [FUW:0]    NFU_L    = (FUW + 1)'(NFU);

  state_t                         state_r;
  state_t                         state_nx_s;
  logic [NREGS-1:0][TAGW-1:0]     rst_r;
  logic [NREGS-1:0][TAGW-1:0]     rst_view_s;
  logic [TAGW-1:0]                wb_tag_s;
  logic [TAGW-1:0]                fetch_tag_s;
  logic                           fu_legal_s;
  logic                           fu_busy_sel_s;
  logic                           rd_busy_s;
  logic                           mispredict_s;
  logic                           accept_s;
  logic                           rd_write_s;
  logic                           jump_nx_s;

  assign wb_tag_s    = TAGW'(wb_fu) + TAG_ONE;
  assign fetch_tag_s = TAGW'(fetch_fu) + TAG_ONE;

  // Post-writeback view of the RST: a matching writeback clears its entry; r0 always reads as ready
  always_comb begin
    rst_view_s = rst_r;
    for (int r = 0; r < NREGS; r++) begin
      if (r == 0) begin
        rst_view_s[r] = TAG_ZERO;
      end else if (wb_valid && (wb_rd == REGW'(r)) && (rst_r[r] == wb_tag_s)) begin
        rst_view_s[r] = TAG_ZERO;
      end else begin
        rst_view_s[r] = rst_r[r];
      end
    end
  end

  // Hazard evaluation and the accept decision; an out-of-range FU index is treated as busy
  always_comb begin
    fu_legal_s = ({1'b0, fetch_fu} < NFU_L);
    if (fu_legal_s) begin
      fu_busy_sel_s = fu_busy[fetch_fu];
    end else begin
      fu_busy_sel_s = 1'b1;
    end
    rd_busy_s    = fetch_wr_en && (fetch_rd != REG_ZERO) && (rst_view_s[fetch_rd] != TAG_ZERO);
    mispredict_s = branch_resolved && branch_miss;
    accept_s     = fetch_valid && (state_r == ST_RUN) && !fu_busy_sel_s && !rd_busy_s && !mispredict_s;
    rd_write_s   = accept_s && fetch_wr_en && (fetch_rd != REG_ZERO);
    freeze       = fetch_valid && !accept_s;
  end

  // Branch FSM next state: wait for resolution after a branch is dispatched
  always_comb begin
    state_nx_s = state_r;
    jump_nx_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (accept_s && fetch_is_branch) begin
          state_nx_s = ST_BR_WAIT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        if (branch_resolved) begin
          state_nx_s = ST_RUN;
          jump_nx_s  = branch_miss;
        end else begin
          state_nx_s = ST_BR_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        jump_nx_s  = 1'b0;
      end
    endcase
  end

  // Branch FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // RST table: a new dispatch to rd overrides a same-cycle writeback clear of rd
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rst_r <= {NREGS{TAG_ZERO}};
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (rd_write_s && (fetch_rd == REGW'(r))) begin
          rst_r[r] <= fetch_tag_s;
        end else begin
          rst_r[r] <= rst_view_s[r];
        end
      end
    end
  end

  // Dispatch packet and jump pulse registers; packet fields hold when nothing is accepted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      disp_valid <= 1'b0;
      disp_fu    <= {FUW{1'b0}};
      disp_rd    <= REG_ZERO;
      disp_t1    <= TAG_ZERO;
      disp_t2    <= TAG_ZERO;
      fust_en    <= {NFU{1'b0}};
      jump       <= 1'b0;
    end else begin
      disp_valid <= accept_s;
      jump       <= jump_nx_s;
      if (accept_s) begin
        disp_fu <= fetch_fu;
        disp_rd <= fetch_rd;
        disp_t1 <= rst_view_s[fetch_rs1];
        disp_t2 <= rst_view_s[fetch_rs2];
        fust_en <= FU_ONE << fetch_fu;
      end else begin
        fust_en <= {NFU{1'b0}};
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  // Saturating statistics counters for accepts, freeze cycles and mispredict pulses
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_dispatched <= 32'd0;
      stat_freeze     <= 32'd0;
      stat_br_miss    <= 16'd0;
    end else begin
      if (accept_s && (stat_dispatched != 32'hFFFF_FFFF)) begin
        stat_dispatched <= stat_dispatched + 32'd1;
      end else begin
        stat_dispatched <= stat_dispatched;
      end
      if (freeze && (stat_freeze != 32'hFFFF_FFFF)) begin
        stat_freeze <= stat_freeze + 32'd1;
      end else begin
        stat_freeze <= stat_freeze;
      end
      if (jump_nx_s && (stat_br_miss != 16'hFFFF)) begin
        stat_br_miss <= stat_br_miss + 16'd1;
      end else begin
        stat_br_miss <= stat_br_miss;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Testbench for dispatch_scoreboard. Expected dispatch packets come from a
// register-level reference model and are queued; a negedge monitor pops and
// compares whenever disp_valid is high. Freeze and jump are checked every cycle.
module tb_dispatch_scoreboard;
  localparam int NREGS = 32;
  localparam int NFU   = 5;
  localparam int REGW  = 5;
  localparam int FUW   = 3;
  localparam int TAGW  = 3;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            fetch_valid, fetch_wr_en, fetch_is_branch;
  logic [FUW-1:0]  fetch_fu;
  logic [REGW-1:0] fetch_rd, fetch_rs1, fetch_rs2;
  logic [NFU-1:0]  fu_busy;
  logic            wb_valid;
  logic [REGW-1:0] wb_rd;
  logic [FUW-1:0]  wb_fu;
  logic            branch_resolved, branch_miss;
  logic            freeze, disp_valid, jump;
  logic [FUW-1:0]  disp_fu;
  logic [REGW-1:0] disp_rd;
  logic [TAGW-1:0] disp_t1, disp_t2;
  logic [NFU-1:0]  fust_en;
`ifdef DISPATCH_STATS_EN
  logic [31:0]     stat_dispatched, stat_freeze;
  logic [15:0]     stat_br_miss;
`endif

  dispatch_scoreboard #(.NREGS(NREGS), .NFU(NFU)) dut (
    .CLK(CLK), .nRST(nRST),
    .fetch_valid(fetch_valid), .fetch_fu(fetch_fu), .fetch_rd(fetch_rd),
    .fetch_rs1(fetch_rs1), .fetch_rs2(fetch_rs2), .fetch_wr_en(fetch_wr_en),
    .fetch_is_branch(fetch_is_branch), .fu_busy(fu_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fu(wb_fu),
    .branch_resolved(branch_resolved), .branch_miss(branch_miss),
    .freeze(freeze), .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_rd(disp_rd),
    .disp_t1(disp_t1), .disp_t2(disp_t2), .fust_en(fust_en), .jump(jump)
`ifdef DISPATCH_STATS_EN
    , .stat_dispatched(stat_dispatched), .stat_freeze(stat_freeze), .stat_br_miss(stat_br_miss)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int fu;
    int rd;
    int t1;
    int t2;
  } pkt_t;

  pkt_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pend[NREGS];   // model: 0 = ready, k = pending on FU k-1
  bit   br_wait;
  bit   exp_jump;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FU indices at or above NFU are illegal stimulus
  always @(posedge CLK) begin
    if (nRST === 1'b1 && fetch_valid === 1'b1)
      assert (fetch_fu < NFU) else $error("illegal fetch_fu %0d", fetch_fu);
  end

  // Monitor: compare every presented dispatch packet with the oldest expected one
  always @(negedge CLK) begin
    pkt_t p;
    logic [NFU-1:0] e_fust;
    if (nRST === 1'b1 && disp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dispatch", 64'(disp_valid), 64'd0);
      end else begin
        p = exp_q.pop_front();
        e_fust = NFU'(1) << p.fu;
        chk("disp_fu", 64'(disp_fu), 64'(p.fu));
        chk("disp_rd", 64'(disp_rd), 64'(p.rd));
        chk("disp_t1", 64'(disp_t1), 64'(p.t1));
        chk("disp_t2", 64'(disp_t2), 64'(p.t2));
        chk("fust_en", 64'(fust_en), 64'(e_fust));
      end
    end
  end

  // One clock cycle: check last jump, drive inputs, check freeze, advance the model
  task automatic step(input bit fv, input int fu, input int rd, input int rs1, input int rs2,
                      input bit wr, input bit br, input logic [NFU-1:0] busy,
                      input bit wv, input int wrd, input int wfu, input bit res, input bit miss);
    int view[NREGS];
    bit acc;
    @(posedge CLK); #1;
    chk("jump", 64'(jump), 64'(exp_jump));
    fetch_valid = fv; fetch_fu = FUW'(fu); fetch_rd = REGW'(rd);
    fetch_rs1 = REGW'(rs1); fetch_rs2 = REGW'(rs2); fetch_wr_en = wr;
    fetch_is_branch = br; fu_busy = busy; wb_valid = wv; wb_rd = REGW'(wrd);
    wb_fu = FUW'(wfu); branch_resolved = res; branch_miss = miss;
    #1;
    for (int r = 0; r < NREGS; r++) begin
      view[r] = pend[r];
      if (wv && r == wrd && r != 0 && pend[r] == wfu + 1) view[r] = 0;
    end
    acc = fv && !br_wait && !busy[fu] && !(wr && rd != 0 && view[rd] != 0) && !(res && miss);
    chk("freeze", 64'(freeze), 64'(fv && !acc));
    if (acc) exp_q.push_back('{fu, rd, view[rs1], view[rs2]});
    pend = view;
    if (acc && wr && rd != 0) pend[rd] = fu + 1;
    exp_jump = 1'b0;
    if (br_wait && res) begin
      br_wait  = 1'b0;
      exp_jump = miss;
    end else if (acc && br) begin
      br_wait = 1'b1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, {NFU{1'b0}}, 0, 0, 0, 0, 0);
  endtask

  task automatic ins(input int fu, input int rd, input int rs1, input int rs2, input bit wr);
    step(1, fu, rd, rs1, rs2, wr, 0, {NFU{1'b0}}, 0, 0, 0, 0, 0);
  endtask

  // Hold reset for two cycles, optionally with writing instructions presented
  task automatic do_reset(input bit populate);
    @(posedge CLK); #1;
    nRST = 1'b0;
    fetch_valid = populate; fetch_wr_en = 1'b1; fetch_fu = 3'd1; fetch_rd = 5'd5;
    fetch_rs1 = 5'd0; fetch_rs2 = 5'd0; fetch_is_branch = 1'b0; fu_busy = 5'b00000;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_fu = 3'd0; branch_resolved = 1'b0; branch_miss = 1'b0;
    foreach (pend[r]) pend[r] = 0;
    br_wait = 1'b0; exp_jump = 1'b0;
    exp_q.delete();
    repeat (2) begin
      @(negedge CLK);
      chk("rst_disp_valid", 64'(disp_valid), 64'd0);
      chk("rst_fust_en", 64'(fust_en), 64'd0);
      chk("rst_jump", 64'(jump), 64'd0);
      chk("rst_disp_fu", 64'(disp_fu), 64'd0);
      chk("rst_disp_rd", 64'(disp_rd), 64'd0);
      chk("rst_disp_t1", 64'(disp_t1), 64'd0);
      chk("rst_disp_t2", 64'(disp_t2), 64'd0);
      fetch_rd = 5'd6; fetch_fu = 3'd2;
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    fetch_valid = 1'b0;
  endtask

  task automatic reset_read_check();
    ins(1, 0, 5, 6, 0);
    idle();
    chk("post_rst_valid", 64'(disp_valid), 64'd1);
    chk("post_rst_t1", 64'(disp_t1), 64'd0);
    chk("post_rst_t2", 64'(disp_t2), 64'd0);
  endtask

  initial begin
    int fu, rd, rs1, rs2, wrd, wfu;
    bit fv, wr, br, wv, res, miss;
    logic [NFU-1:0] busy;

    nRST = 1'b0;
    do_reset(1);
    reset_read_check();

    // RAW: FU2 writes r7, FU0 reads r7
    ins(2, 7, 0, 0, 1);
    ins(0, 0, 7, 0, 0);
    idle();
    chk("raw_t1", 64'(disp_t1), 64'd3);
    chk("raw_t2", 64'(disp_t2), 64'd0);
    chk("raw_fust", 64'(fust_en), 64'b00001);

    // WAW on r9 until FU1 writes it back; dispatch in the writeback cycle
    ins(1, 9, 0, 0, 1);
    ins(3, 9, 0, 0, 1);
    chk("waw_freeze", 64'(freeze), 64'd1);
    ins(3, 9, 0, 0, 1);
    chk("waw_freeze2", 64'(freeze), 64'd1);
    step(1, 3, 9, 0, 0, 1, 0, {NFU{1'b0}}, 1, 9, 1, 0, 0);
    chk("waw_release", 64'(freeze), 64'd0);
    idle();
    ins(0, 0, 9, 0, 0);
    idle();
    chk("waw_new_tag", 64'(disp_t1), 64'd4);

    // Structural hazard on FU2
    step(1, 2, 0, 1, 1, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
    chk("busy_freeze", 64'(freeze), 64'd1);

    // Writeback bypass, then a stale writeback
    ins(0, 4, 0, 0, 1);
    step(1, 1, 0, 4, 0, 0, 0, {NFU{1'b0}}, 1, 4, 0, 0, 0);
    idle();
    chk("bypass_t1", 64'(disp_t1), 64'd0);
    ins(0, 4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, {NFU{1'b0}}, 1, 4, 1, 0, 0);
    ins(2, 0, 4, 0, 0);
    idle();
    chk("stale_wb_t1", 64'(disp_t1), 64'd1);

    // r0 never becomes pending
    ins(1, 0, 0, 0, 1);
    ins(2, 0, 0, 0, 1);
    chk("r0_no_waw", 64'(freeze), 64'd0);
    idle();
    chk("r0_t1", 64'(disp_t1), 64'd0);

    // Branch then mispredict
    step(1, 3, 0, 0, 0, 0, 1, {NFU{1'b0}}, 0, 0, 0, 0, 0);
    ins(0, 0, 1, 2, 0);
    chk("br_freeze", 64'(freeze), 64'd1);
    step(1, 0, 0, 1, 2, 0, 0, {NFU{1'b0}}, 0, 0, 0, 1, 1);
    chk("br_squash", 64'(freeze), 64'd1);
    ins(0, 0, 1, 2, 0);
    chk("br_jump", 64'(jump), 64'd1);
    chk("br_jump_novalid", 64'(disp_valid), 64'd0);
    chk("br_run_accept", 64'(freeze), 64'd0);
    idle();
    chk("br_jump_end", 64'(jump), 64'd0);
    chk("br_after_valid", 64'(disp_valid), 64'd1);

    // Resolve with no branch pending is ignored
    step(0, 0, 0, 0, 0, 0, 0, {NFU{1'b0}}, 0, 0, 0, 1, 1);
    idle();
    chk("stray_resolve", 64'(jump), 64'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      fv   = ($urandom_range(0, 3) != 0);
      fu   = $urandom_range(0, NFU - 1);
      rd   = $urandom_range(0, 7);
      rs1  = $urandom_range(0, 7);
      rs2  = $urandom_range(0, 7);
      wr   = ($urandom_range(0, 3) != 0);
      br   = ($urandom_range(0, 15) == 0);
      for (int b = 0; b < NFU; b++) busy[b] = ($urandom_range(0, 7) == 0);
      wv   = ($urandom_range(0, 1) == 1);
      wrd  = $urandom_range(1, 7);
      if (pend[wrd] != 0 && $urandom_range(0, 3) != 0) wfu = pend[wrd] - 1;
      else wfu = $urandom_range(0, NFU - 1);
      res  = br_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      miss = ($urandom_range(0, 1) == 1);
      step(fv, fu, rd, rs1, rs2, wr, br, busy, wv, wrd, wfu, res, miss);
      if (i == 1500) begin
        do_reset(1);
        reset_read_check();
      end
    end

`ifdef DISPATCH_STATS_EN
    do_reset(0);
    for (int i = 0; i < 10; i++) ins(i % NFU, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 0, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
    idle();
    chk("stat_dispatched", 64'(stat_dispatched), 64'd10);
    chk("stat_freeze", 64'(stat_freeze), 64'd3);
    chk("stat_br_miss0", 64'(stat_br_miss), 64'd0);
    step(1, 1, 0, 0, 0, 0, 1, {NFU{1'b0}}, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, {NFU{1'b0}}, 0, 0, 0, 1, 1);
    idle();
    chk("stat_br_miss1", 64'(stat_br_miss), 64'd1);
`endif

    repeat (3) idle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
